// File: rtl/sample_pkg.sv
// -----------------------------------------------------------------------------
// sample_pkg
// Shared constants and helpers for the sample capture path. It is used by the
// packet generator, the memory writer and the readback blocks.
//   calc_dw         : bits per memory word
//   calc_wpp        : memory words per sample packet
//   calc_addr_width : word-address width for a given memory capacity
//   DROP_CNT_W      : width of the saturating dropped-packet counter
//   wr_state_e      : memory-writer FSM states
// -----------------------------------------------------------------------------
package sample_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } wr_state_e;

    function automatic int calc_dw(input int mem_word_bytes);
        return 8 * mem_word_bytes;
    endfunction

    function automatic int calc_wpp(input int packet_bits, input int mem_word_bytes);
        return packet_bits / (8 * mem_word_bytes);
    endfunction

    function automatic int calc_addr_width(input int capacity_bytes, input int mem_word_bytes);
        return $clog2(capacity_bytes / mem_word_bytes);
    endfunction

endpackage

// File: rtl/sample_mem_writer_if.sv
// -----------------------------------------------------------------------------
// sample_mem_writer_if
// Word-write port between the sample memory writer and the memory controller.
//   mem_wr_req  : writer -> controller, word write request
//   mem_wr_addr : writer -> controller, word address
//   mem_wr_data : writer -> controller, word data
//   mem_wr_ack  : controller -> writer, word accepted when req & ack
// -----------------------------------------------------------------------------
interface sample_mem_writer_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 16
);
    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_ack;

    modport master (
        output mem_wr_req,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_wr_ack
    );

    modport slave (
        input  mem_wr_req,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_wr_ack
    );
endinterface

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO with a registered occupancy count and a flush.
//   clk, reset : clock, asynchronous active-high reset (control only)
//   flush_i    : empty the FIFO (wins over push/pop)
//   push_i     : write wdata_i (ignored while full)
//   pop_i      : advance the head (ignored while empty)
//   rdata_o    : head entry (valid while not empty)
//   full_o, empty_o, count_o : status from the registered count
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/sample_mem_writer.sv
// -----------------------------------------------------------------------------
// sample_mem_writer
// Buffers sample packets from the packet generator and writes each packet to
// memory as WPP consecutive words (low word first) at address slot*WPP.
//   clk, reset     : clock, asynchronous active-high reset
//   write_enable   : one-cycle strobe, samplePacket/sample_number valid
//   samplePacket   : packet to store
//   sample_number  : packet slot index (low ADDR_WIDTH bits used)
//   clear          : synchronous start-of-capture clear
//   mem            : word-write port (req/addr/data out, ack in)
//   busy           : FIFO non-empty or a packet in flight
//   overflow       : sticky, at least one packet dropped
//   dropped_count  : saturating count of dropped packets
// -----------------------------------------------------------------------------
module sample_mem_writer
    import sample_pkg::*;
#(
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int MEMORY_WORD_WIDTH   = 2,
    parameter int MEMORY_CAPACITY     = 2**27,
    parameter int ADDR_WIDTH          = calc_addr_width(MEMORY_CAPACITY, MEMORY_WORD_WIDTH),
    parameter int FIFO_DEPTH          = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write_enable,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket,
    input  logic [31:0]                    sample_number,
    input  logic                           clear,
    sample_mem_writer_if.master            mem,
    output logic                           busy,
    output logic                           overflow,
    output logic [DROP_CNT_W-1:0]          dropped_count
);
    localparam int WPP     = calc_wpp(SAMPLE_PACKET_WIDTH, MEMORY_WORD_WIDTH);
    localparam int DW      = calc_dw(MEMORY_WORD_WIDTH);
    localparam int ENTRY_W = ADDR_WIDTH + SAMPLE_PACKET_WIDTH;
    localparam int IDX_W   = (WPP > 1) ? $clog2(WPP) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WPP - 1);
    localparam logic [ADDR_WIDTH-1:0] WPP_A    = ADDR_WIDTH'(WPP);

    wr_state_e                      state_q, state_d;
    logic [SAMPLE_PACKET_WIDTH-1:0] pkt_q, pkt_d;
    logic [ADDR_WIDTH-1:0]          base_q, base_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           overflow_q;
    logic [DROP_CNT_W-1:0]          dropped_q;

    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [CNT_W-1:0]               fifo_count;
    logic [ENTRY_W-1:0]             fifo_head;
    logic                           drop;
    logic                           unused_sample_bits;

    assign unused_sample_bits = ^sample_number[31:ADDR_WIDTH];

    // clear wins over a same-cycle strobe; that packet is neither stored nor dropped.
    assign fifo_push = write_enable & ~fifo_full & ~clear;
    assign drop      = write_enable &  fifo_full & ~clear;

    sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({sample_number[ADDR_WIDTH-1:0], samplePacket}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        base_d   = base_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !clear) begin
                    fifo_pop = 1'b1;
                    pkt_d    = fifo_head[SAMPLE_PACKET_WIDTH-1:0];
                    base_d   = fifo_head[SAMPLE_PACKET_WIDTH +: ADDR_WIDTH] * WPP_A;
                    idx_d    = '0;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (mem.mem_wr_ack) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    // Chain straight into the next packet to keep req high.
                    end else if (!fifo_empty && !clear) begin
                        fifo_pop = 1'b1;
                        pkt_d    = fifo_head[SAMPLE_PACKET_WIDTH-1:0];
                        base_d   = fifo_head[SAMPLE_PACKET_WIDTH +: ADDR_WIDTH] * WPP_A;
                        idx_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pkt_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else if (clear) begin
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (dropped_q != '1) dropped_q <= dropped_q + DROP_CNT_W'(1);
        end
    end

    // Outputs come from registers only, so reset drops req without a clock edge.
    assign mem.mem_wr_req  = (state_q == ST_XFER);
    assign mem.mem_wr_addr = base_q + ADDR_WIDTH'(idx_q);
    assign mem.mem_wr_data = pkt_q[int'(idx_q)*DW +: DW];

    assign busy          = (fifo_count != '0) | (state_q == ST_XFER);
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;
endmodule

// File: tb/tb_sample_mem_writer.sv
module tb_sample_mem_writer;
    localparam int PW    = 32;
    localparam int MWW   = 2;
    localparam int AW    = 26;
    localparam int DW    = 16;
    localparam int WPP   = 2;
    localparam int DEPTH = 16;
    localparam int WE_W  = AW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_enable;
    logic [PW-1:0] samplePacket;
    logic [31:0]   sample_number;
    logic          clear;
    logic          busy;
    logic          overflow;
    logic [15:0]   dropped_count;

    int n_cmp = 0;
    int n_mis = 0;

    logic [WE_W-1:0] exp_q[$];
    logic [WE_W-1:0] obs_q[$];

    sample_mem_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    sample_mem_writer #(
        .SAMPLE_PACKET_WIDTH (PW),
        .MEMORY_WORD_WIDTH   (MWW),
        .MEMORY_CAPACITY     (2**27),
        .ADDR_WIDTH          (AW),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .samplePacket  (samplePacket),
        .sample_number (sample_number),
        .clear         (clear),
        .mem           (mem_if),
        .busy          (busy),
        .overflow      (overflow),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    // Record every word the controller accepts.
    always @(posedge clk) begin
        if (!reset && mem_if.mem_wr_req && mem_if.mem_wr_ack)
            obs_q.push_back({mem_if.mem_wr_addr, mem_if.mem_wr_data});
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a packet in slot s occupies words s*WPP .. s*WPP+WPP-1 (mod 2**AW),
    // lowest data word first.
    task automatic add_packet(input logic [PW-1:0] p, input logic [31:0] s);
        logic [63:0] base;
        base = 64'(s) * 64'(WPP);
        for (int i = 0; i < WPP; i++)
            exp_q.push_back({AW'(base + 64'(i)), p[i*DW +: DW]});
    endtask

    task automatic strobe(input logic [PW-1:0] p, input logic [31:0] s, input bit expect_kept);
        write_enable  = 1'b1;
        samplePacket  = p;
        sample_number = s;
        if (expect_kept) add_packet(p, s);
        step();
        write_enable = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_w%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int bound, input bit rand_ack);
        int k;
        k = 0;
        while (busy && k < bound) begin
            if (rand_ack) mem_if.mem_wr_ack = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        check({tag, "_drained"}, 64'(busy), 64'(0));
        mem_if.mem_wr_ack = 1'b1;
        step();
    endtask

    initial begin
        reset             = 1'b1;
        write_enable      = 1'b0;
        samplePacket      = '0;
        sample_number     = '0;
        clear             = 1'b0;
        mem_if.mem_wr_ack = 1'b0;
        repeat (3) step();

        check("rst_req",      64'(mem_if.mem_wr_req),  64'(0));
        check("rst_addr",     64'(mem_if.mem_wr_addr), 64'(0));
        check("rst_data",     64'(mem_if.mem_wr_data), 64'(0));
        check("rst_busy",     64'(busy),               64'(0));
        check("rst_overflow", 64'(overflow),           64'(0));
        check("rst_dropped",  64'(dropped_count),      64'(0));
        reset = 1'b0;
        step();

        // Single packet with ack high: first req two cycles after the strobe.
        mem_if.mem_wr_ack = 1'b1;
        strobe(32'hABCD1234, 32'd5, 1'b1);
        check("single_req_n1",  64'(mem_if.mem_wr_req),  64'(0));
        check("single_busy_n1", 64'(busy),               64'(1));
        step();
        check("single_req_n2",  64'(mem_if.mem_wr_req),  64'(1));
        check("single_addr_w0", 64'(mem_if.mem_wr_addr), 64'(10));
        check("single_data_w0", 64'(mem_if.mem_wr_data), 64'(16'h1234));
        step();
        check("single_addr_w1", 64'(mem_if.mem_wr_addr), 64'(11));
        check("single_data_w1", 64'(mem_if.mem_wr_data), 64'(16'hABCD));
        step();
        check("single_req_end",  64'(mem_if.mem_wr_req), 64'(0));
        check("single_busy_end", 64'(busy),              64'(0));
        compare_writes("single");

        // Ack stall: address and data held while ack is low.
        mem_if.mem_wr_ack = 1'b0;
        strobe(32'hABCD1234, 32'd5, 1'b1);
        step();
        for (int s = 0; s < 3; s++) begin
            check($sformatf("stall_req_%0d", s),  64'(mem_if.mem_wr_req),  64'(1));
            check($sformatf("stall_addr_%0d", s), 64'(mem_if.mem_wr_addr), 64'(10));
            check($sformatf("stall_data_%0d", s), 64'(mem_if.mem_wr_data), 64'(16'h1234));
            step();
        end
        mem_if.mem_wr_ack = 1'b1;
        wait_idle("stall", 50, 1'b0);
        compare_writes("stall");

        // Overflow: with ack low the first packet moves into the transfer stage,
        // so 1 + DEPTH strobes fit and the next one is dropped.
        mem_if.mem_wr_ack = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++)
            strobe(PW'($urandom), 32'(200 + i), (i < DEPTH + 1));
        check("ovf_flag",    64'(overflow),      64'(1));
        check("ovf_dropped", 64'(dropped_count), 64'(1));
        check("ovf_busy",    64'(busy),          64'(1));
        mem_if.mem_wr_ack = 1'b1;
        wait_idle("ovf", 200, 1'b0);
        compare_writes("ovf");
        check("ovf_flag_sticky", 64'(overflow), 64'(1));

        // clear together with a strobe: clear wins, packet not stored, no drop.
        clear = 1'b1;
        strobe(32'h5555AAAA, 32'd7, 1'b0);
        clear = 1'b0;
        check("clr_overflow", 64'(overflow),      64'(0));
        check("clr_dropped",  64'(dropped_count), 64'(0));
        check("clr_busy",     64'(busy),          64'(0));
        step();
        check("clr_req", 64'(mem_if.mem_wr_req), 64'(0));
        compare_writes("clr");

        // Address wrap: last slot, then slot 0.
        mem_if.mem_wr_ack = 1'b1;
        strobe(PW'($urandom), 32'h01FF_FFFF, 1'b1);
        strobe(PW'($urandom), 32'h0000_0000, 1'b1);
        wait_idle("wrap", 50, 1'b0);
        check("wrap_first_addr", 64'(obs_q.size() > 0 ? obs_q[0][WE_W-1:DW] : '0), 64'(26'h3FFFFFE));
        compare_writes("wrap");

        // clear mid-transfer: the in-flight packet finishes, queued ones vanish.
        mem_if.mem_wr_ack = 1'b0;
        strobe(32'hDEAD_BEEF, 32'd40, 1'b1);
        for (int i = 1; i < 4; i++)
            strobe(PW'($urandom), 32'(40 + i), 1'b0);
        mem_if.mem_wr_ack = 1'b1;
        step();
        mem_if.mem_wr_ack = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("cmid_req_held", 64'(mem_if.mem_wr_req), 64'(1));
        mem_if.mem_wr_ack = 1'b1;
        step();
        check("cmid_req",      64'(mem_if.mem_wr_req), 64'(0));
        check("cmid_busy",     64'(busy),              64'(0));
        check("cmid_overflow", 64'(overflow),          64'(0));
        step();
        compare_writes("cmid");

        // Randomized packets, slots, gaps and ack pattern.
        begin
            int sent;
            sent = 0;
            while (sent < 12) begin
                mem_if.mem_wr_ack = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) != 0) begin
                    strobe(PW'($urandom), $urandom, 1'b1);
                    sent++;
                end else begin
                    step();
                end
            end
        end
        wait_idle("rand", 400, 1'b1);
        compare_writes("rand");
        check("rand_dropped", 64'(dropped_count), 64'(0));

        // Asynchronous reset while a transfer is pending.
        mem_if.mem_wr_ack = 1'b0;
        strobe(32'h0BAD_F00D, 32'd3, 1'b0);
        strobe(32'h1234_5678, 32'd4, 1'b0);
        check("arst_req_before", 64'(mem_if.mem_wr_req), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("arst_req_now",  64'(mem_if.mem_wr_req), 64'(0));
        check("arst_busy_now", 64'(busy),              64'(0));
        step();
        reset = 1'b0;
        mem_if.mem_wr_ack = 1'b1;
        step();
        step();
        check("arst_req_after",  64'(mem_if.mem_wr_req), 64'(0));
        check("arst_busy_after", 64'(busy),              64'(0));
        obs_q.delete();
        exp_q.delete();
        strobe(32'hCAFE_0001, 32'd9, 1'b1);
        wait_idle("arst_resume", 50, 1'b0);
        compare_writes("arst_resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
